// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: opcodes, funct codes,
// ALU control codes, datapath select values and the multicycle state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp as produced by the main control; 11 is unused and falls back to add
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and funct to the ALU control code.
// Shared with the single-cycle control, so it carries no state.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALU_Control,
  output logic       illegal_funct
);

  always_comb begin
    ALU_Control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALU_Control = ALU_ADD;
      ALUOP_SUB: ALU_Control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ALU_Control = ALU_ADD;
          FN_SUB:  ALU_Control = ALU_SUB;
          FN_AND:  ALU_Control = ALU_AND;
          FN_OR:   ALU_Control = ALU_OR;
          FN_SLT:  ALU_Control = ALU_SLT;
          // unsupported funct leaves the ALU on add; the flag aborts the instruction
          default: illegal_funct = 1'b1;
        endcase
      end
      default: ALU_Control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS core. Moore outputs per state, with
// memory stalls on MemReady and the branch PC load qualified by Zero.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_FETCH    | read instruction at PC, PC+4; waits for MemReady
// S_DECODE   | register read, branch target into ALUOut, dispatch on opcode
// S_MEMADR   | lw/sw effective address A + SignImm
// S_MEMREAD  | data read at ALUOut; waits for MemReady
// S_MEMWB    | load data into rt
// S_MEMWRITE | data write at ALUOut; waits for MemReady
// S_EXECUTE  | R-type ALU operation selected by funct
// S_ALUWB    | ALU result into rd
// S_BRANCH   | A - B compare, PC <= ALUOut when Zero
// S_ADDIEXEC | A + SignImm
// S_ADDIWB   | ALU result into rt
// S_JUMP     | PC <= jump target
module multicycle_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl;
  logic       illegal_funct;
  logic       pc_write;
  logic       branch;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // ALUOp depends only on state, keeping the decoder out of the output block's loop
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state)
      S_EXECUTE: alu_op = ALUOP_FUNCT;
      S_BRANCH:  alu_op = ALUOP_SUB;
      default:   alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp         (alu_op),
    .Funct         (Funct),
    .ALU_Control   (alu_ctrl),
    .illegal_funct (illegal_funct)
  );

  always_comb begin
    state_next   = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    PCSrc        = PCSRC_ALU;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite    = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEXEC;
          OP_J:         state_next = S_JUMP;
          default: begin
            IllegalInstr = 1'b1;
            state_next   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_LW:   state_next = S_MEMREAD;
          OP_SW:   state_next = S_MEMWRITE;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_next = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA      = 1'b1;
        IllegalInstr = illegal_funct;
        state_next   = illegal_funct ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        branch     = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        state_next = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    PCEn        = pc_write | (branch & Zero);
    ALU_Control = alu_ctrl;

    // reset silences every strobe and select, whatever state the register holds
    if (reset) begin
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IorD         = 1'b0;
      IRWrite      = 1'b0;
      PCEn         = 1'b0;
      PCSrc        = 2'b00;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALU_Control  = 3'b000;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Control unit for the multicycle MIPS core, on the decode side of the datapath's control interface. It reads Opcode/Funct from the instruction register and the ALU Zero flag, and sequences fetch/decode/execute/memory/writeback states. It drives every datapath select and write strobe. Memory accesses stall on a ready handshake, so one memory serves both instructions and data.

Parameters:
none (encodings fixed in package)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  Instr[31:26] from instruction register
Funct  in  6  Instr[5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes current access this cycle
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load instruction register
PCEn  out  1  PC load = PCWrite | (Branch & Zero)
PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
ALUSrcA  out  1  0=PC, 1=register A
ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
ALU_Control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=Data register
RegWrite  out  1  register file write
IllegalInstr  out  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- Reset: synchronous. While reset=1 every output is 0. The next state is FETCH.
- Outputs are Moore (decoded from state). The only exceptions are PCEn, IRWrite and the FETCH/MEM* advance, which also depend on MemReady or Zero.
- States and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU add, PCSrc=00. IRWrite and PCWrite assert only when MemReady=1. Stays in FETCH while MemReady=0, otherwise goes to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALU add (branch target into ALUOut). Next state by opcode:
    - lw (100011) or sw (101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) -> BRANCH
    - addi (001000) -> ADDIEXEC
    - j (000010) -> JUMP
    - anything else -> FETCH with IllegalInstr=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
  - MEMWRITE: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_Control from funct, then ALUWB.
    - Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Unsupported funct: IllegalInstr=1 and go to FETCH (no writeback).
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01. PCEn=Zero. Then FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
  - JUMP: PCSrc=10, PCWrite=1, then FETCH.
- Latency with MemReady always 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - Each memory wait cycle adds 1.
- At most one of RegWrite, MemWrite and IRWrite is high in any cycle.
- MemRead and MemWrite are never high together.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction (including during a stall) aborts it. The next cycle after reset deasserts is FETCH with no write strobe.
- Unused state encodings go to FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU_Control codes
  - the state enum (4-bit)
- Sub-module alu_decoder (ALUOp[1:0], Funct -> ALU_Control, illegal flag). It is combinational and reusable by the single-cycle control.

Test Plan:
- lw 0x8C080004 with MemReady=1:
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH
  - RegWrite=1 with MemtoReg=1 and RegDst=0 only in cycle 5
- sw 0xAC090008 with MemReady low for 3 cycles in MEMWRITE: MemWrite held 4 cycles, IorD=1 throughout, then FETCH; no RegWrite.
- beq 0x11090003 run twice:
  - Zero=1: PCEn=1 and PCSrc=01 in cycle 3
  - Zero=0: PCEn=0 in cycle 3
- R-type sub 0x01095022: ALU_Control=110 in EXECUTE, RegDst=1 and RegWrite=1 in ALUWB; repeat with slt funct -> 111.
- Illegal: opcode 111111 -> IllegalInstr pulse in DECODE, next state FETCH, no writes; funct 000111 -> pulse in EXECUTE.
- Reset asserted during a FETCH stall: all outputs 0 while reset=1; first post-reset cycle is FETCH with MemRead=1 and IRWrite=0 until MemReady.
